// File: rtl/mp_add_seq.sv
// ----------------------------------------------------------------------------
// mp_add_seq -- multi-precision add/subtract sequencer
//
// Time-shares a single 8-bit ripple-carry adder (ripple8bit) across the bytes
// of W = 8*NBYTES bit operands. One byte is processed per clock, LSB first,
// with the inter-byte carry held in a register. Subtraction is done as
// A + ~B + 1 by inverting B on capture and seeding the carry with 1.
//
// Parameters:
//   NBYTES   operand width in bytes, legal range 2..16 (default 4)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   command request, sampled only while idle
//   op_sub    in   0 = A+B, 1 = A-B
//   op_a      in   operand A (W bits), captured on accept
//   op_b      in   operand B (W bits), captured on accept
//   busy      out  high while a command is running or completing
//   done      out  one-cycle pulse when result is valid
//   result    out  W-bit sum/difference (registered, held until next command)
//   c_out     out  carry out of the MSB; for subtract 1 = no borrow
//   overflow  out  signed two's-complement overflow
//   zero      out  result is all-zero (only with MP_ADD_SEQ_ZERO_FLAG_EN)
//
// Build option: define MP_ADD_SEQ_ZERO_FLAG_EN to add the zero flag output.
// ----------------------------------------------------------------------------

// 8-bit ripple-carry adder; ovf is carry into bit 7 XOR carry out of bit 7.
module ripple8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout,
   output logic       ovf
);
   logic [8:0] c_s;

   // Bit-by-bit carry chain
   always_comb begin
      c_s    = 9'd0;
      sum    = 8'd0;
      c_s[0] = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c_s[i];
         c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c_s[8];
   assign ovf  = c_s[7] ^ c_s[8];
endmodule

module mp_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op_sub,
   input  logic [8*NBYTES-1:0]   op_a,
   input  logic [8*NBYTES-1:0]   op_b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  c_out,
   output logic                  overflow
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
   ,
   output logic                  zero
`endif
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = $clog2(NBYTES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;          // B already inverted for subtract
   logic [W-1:0]     result_r;
   logic             carry_r;
   logic [IDXW-1:0]  idx_r;
   logic             busy_r;
   logic             done_r;
   logic             c_out_r;
   logic             ovf_r;

   logic [IDXW+2:0]  base_s;       // bit offset of the current byte
   logic [7:0]       a_byte_s;
   logic [7:0]       b_byte_s;
   logic [7:0]       sum_s;
   logic             add_cout_s;
   logic             add_ovf_s;
   logic             last_s;

`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
   logic [7:0]       zacc_r;       // OR of all byte sums produced so far
   logic             zero_r;
`endif

   assign base_s   = {idx_r, 3'b000};
   assign a_byte_s = a_r[base_s +: 8];
   assign b_byte_s = b_r[base_s +: 8];
   assign last_s   = (idx_r == IDXW'(NBYTES - 1));

   ripple8bit u_adder (
      .a    (a_byte_s),
      .b    (b_byte_s),
      .cin  (carry_r),
      .sum  (sum_s),
      .cout (add_cout_s),
      .ovf  (add_ovf_s)
   );

   // Sequencer FSM: command capture, per-byte accumulation and flag update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         a_r      <= {W{1'b0}};
         b_r      <= {W{1'b0}};
         result_r <= {W{1'b0}};
         carry_r  <= 1'b0;
         idx_r    <= {IDXW{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         c_out_r  <= 1'b0;
         ovf_r    <= 1'b0;
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
         zacc_r   <= 8'd0;
         zero_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= op_a;
                  b_r     <= op_sub ? ~op_b : op_b;
                  carry_r <= op_sub;           // +1 of the two's complement
                  idx_r   <= {IDXW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
                  zacc_r  <= 8'd0;
`endif
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end

            ST_RUN: begin
               result_r[base_s +: 8] <= sum_s;
               carry_r               <= add_cout_s;
               idx_r                 <= idx_r + IDXW'(1);
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
               zacc_r                <= zacc_r | sum_s;
`endif
               if (last_s) begin
                  c_out_r <= add_cout_s;
                  ovf_r   <= add_ovf_s;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
                  // include the MSB byte, which is not yet in the accumulator
                  zero_r  <= ~|(zacc_r | sum_s);
`endif
               end else begin
                  done_r  <= 1'b0;
                  state_r <= ST_RUN;
               end
            end

            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end

            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign result   = result_r;
   assign c_out    = c_out_r;
   assign overflow = ovf_r;
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
   assign zero     = zero_r;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// ----------------------------------------------------------------------------
// tb_mp_add_seq -- self-checking bench for mp_add_seq (NBYTES = 4)
//
// A reference model computes each command's result with plain W-bit
// arithmetic and tracks command latency as a phase count since accept. A
// compare process checks busy/done every cycle and result/flags whenever
// they are meaningful. Directed commands pin the model with literal values;
// a randomized section exercises start held high, gaps and corner operands.
// ----------------------------------------------------------------------------
module tb_mp_add_seq;
   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op_sub;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          c_out;
   logic          overflow;
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
   logic          zero;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mp_add_seq #(.NBYTES(NB)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow)
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
      ,
      .zero     (zero)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] m_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      return sub ? (a - b) : (a + b);
   endfunction

   function automatic logic m_cout(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return sub ? (a >= b) : s[W];
   endfunction

   // exact signed result in W+2 bits; overflow if it does not fit in W bits
   function automatic logic m_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic [W+1:0] sa;
      logic [W+1:0] sb;
      logic [W+1:0] r;
      sa = {{2{a[W-1]}}, a};
      sb = {{2{b[W-1]}}, b};
      r  = sub ? (sa - sb) : (sa + sb);
      return r[W] ^ r[W-1];
   endfunction

   // phase: 0 idle, 1..NB running, NB+1 done cycle
   int           p = 0;
   logic [W-1:0] pend_res = '0;
   logic         pend_c = 1'b0, pend_v = 1'b0, pend_z = 1'b0;
   logic [W-1:0] exp_res = '0;
   logic         exp_c = 1'b0, exp_v = 1'b0, exp_z = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         p       <= 0;
         exp_res <= '0;
         exp_c   <= 1'b0;
         exp_v   <= 1'b0;
         exp_z   <= 1'b0;
      end else if (p == 0) begin
         if (start === 1'b1) begin
            p        <= 1;
            pend_res <= m_res(op_a, op_b, op_sub);
            pend_c   <= m_cout(op_a, op_b, op_sub);
            pend_v   <= m_ovf(op_a, op_b, op_sub);
            pend_z   <= (m_res(op_a, op_b, op_sub) == '0);
         end
      end else if (p == NB) begin
         p       <= NB + 1;
         exp_res <= pend_res;
         exp_c   <= pend_c;
         exp_v   <= pend_v;
         exp_z   <= pend_z;
      end else if (p == NB + 1) begin
         p <= 0;
      end else begin
         p <= p + 1;
      end
   end

   // compare process
   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(p != 0));
      chk("done", 64'(done), 64'(p == NB + 1));
      if (p == 0 || p == NB + 1) begin
         chk("result", 64'(result), 64'(exp_res));
         chk("c_out", 64'(c_out), 64'(exp_c));
         chk("overflow", 64'(overflow), 64'(exp_v));
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
         chk("zero", 64'(zero), 64'(exp_z));
`endif
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   // one command with start pulsed for one cycle; literal expectations
   task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] er, input logic ec, input logic ev, input logic ez);
      int cyc;
      @(negedge clk);
      op_a = a; op_b = b; op_sub = sub; start = 1'b1;
      @(posedge clk);
      #1 chk("accept_busy", 64'(busy), 64'd1);
      @(negedge clk);
      start = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom_range(0, 1));
      cyc = 1;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), 64'd5);
      chk("lit_result", 64'(result), 64'(er));
      chk("lit_c_out", 64'(c_out), 64'(ec));
      chk("lit_overflow", 64'(overflow), 64'(ev));
`ifdef MP_ADD_SEQ_ZERO_FLAG_EN
      chk("lit_zero", 64'(zero), 64'(ez));
`else
      if (ez === 1'bx) $display("unexpected x in zero expectation");
`endif
   endtask

   initial begin
      int ndone;
      rst = 1'b0; start = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_c_out", 64'(c_out), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_cmd(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_cmd(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_cmd(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_cmd(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

      // back-to-back: start held high, operands changing every cycle
      @(negedge clk);
      start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'b0;
      ndone = 0;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
         if (k == 5) chk("b2b_gap_idle", 64'(busy), 64'd0);
         if (k == 6) chk("b2b_reaccept", 64'(busy), 64'd1);
         op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      chk("b2b_dones", 64'(ndone), 64'd3);

      // reset during the second RUN cycle
      @(negedge clk);
      op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_result", 64'(result), 64'd0);
      chk("mid_rst_c_out", 64'(c_out), 64'd0);
      chk("mid_rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("mid_rst_no_done", 64'(ndone), 64'd0);
      run_cmd(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

      // carry through every byte, then result must hold while idle
      run_cmd(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_result", 64'(result), 64'h0100_0000);
      end

      // randomized commands, start bursts and idle gaps
      for (int n = 0; n < 150; n++) begin
         int len;
         @(negedge clk);
         start = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         len = $urandom_range(1, 8);
         for (int j = 0; j < len; j++) begin
            op_a = pick(); op_b = pick(); op_sub = 1'($urandom_range(0, 1));
            start = 1'b1;
            @(negedge clk);
         end
         start = 1'b0;
      end
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that time-shares one 8-bit ripple-carry adder (ripple8bit) across the bytes of wide operands.
- Processes one byte per clock, LSB first, and chains the carry through a register.
- Accepts a command with a start/busy/done handshake and reports result, carry-out and signed overflow.
- Sits between the ALU control logic and the 8-bit adder datapath for operations wider than 8 bits.

Parameters:
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B.
- op_a  input  W  operand A, captured on accept.
- op_b  input  W  operand B, captured on accept.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  W  sum/difference, registered.
- c_out  output  1  carry out of the MSB byte; for subtract, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow of the W-bit operation.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, c_out=0, overflow=0, internal byte index=0, carry register=0. Reset mid-operation aborts the command; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 on the edge, capture op_a and (op_sub ? ~op_b : op_b) into internal registers.
  - Set carry register = op_sub and index=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - The adder sees A byte[index], B' byte[index] and the carry register.
  - Each edge: result byte[index] <= adder sum; carry register <= adder c_out; index <= index+1.
  - When index == NBYTES-1, also c_out <= adder c_out and overflow <= adder overflow (carry into MSB XOR carry out of MSB), then go to DONE.
- DONE: done=1 for exactly this cycle, busy still 1; next edge goes to IDLE with done=0, busy=0.
- Latency: start accepted on edge T; done high in the cycle after edge T+NBYTES; next command can be accepted at edge T+NBYTES+2.
- start in RUN or DONE is ignored and not queued. op_a, op_b and op_sub may change freely after accept.
- result, c_out and overflow hold their values from the last completed command until the next command writes them.
- Partial result bytes update during RUN; result is only valid while done=1 and afterwards.
- Carry and index are internal registers only; index wraps to 0 on entry to RUN.
- The adder is combinational; no more than one adder instance is used.

Optional Feature:
- Macro MP_ADD_SEQ_ZERO_FLAG_EN.
- When defined:
  - Extra output port zero (1 bit, reset 0).
  - An internal accumulator ORs each byte sum during RUN; it is cleared on accept.
  - zero is registered alongside c_out/overflow and equals 1 iff all W result bits are 0. It holds its value like the other flags.
- When undefined: no zero port and no accumulator logic.

Test Plan (NBYTES=4):
- Add 0x7FFFFFFF+0x00000001, start pulsed one cycle -> done exactly 5 cycles after accept edge; result=0x80000000, c_out=0, overflow=1; busy high for 5 cycles.
- Add 0xFFFFFFFF+0x00000001 -> result=0x00000000, c_out=1, overflow=0; with MP_ADD_SEQ_ZERO_FLAG_EN, zero=1.
- Sub 0x00000005-0x00000007 -> result=0xFFFFFFFE, c_out=0 (borrow), overflow=0; then sub 0x80000000-0x00000001 -> result=0x7FFFFFFF, c_out=1, overflow=1.
- Back-to-back: start held high continuously with changing operands -> second command accepted only at accept edge+6. Operands presented during RUN/DONE are ignored. Exactly one done pulse per accepted command.
- Reset mid-op: assert rst asynchronously during the 2nd RUN cycle -> busy, done, result, c_out and overflow all 0 immediately; no done pulse after release; a new command then completes correctly (0x12345678+0x11111111=0x23456789, c_out=0, overflow=0).
- Carry chain across all bytes: 0x00FFFFFF+0x00000001 -> result=0x01000000, c_out=0, overflow=0; result unchanged for 10 idle cycles after done.
